int_controller: RTL and testbench

- Platform-level interrupt aggregator that sits directly upstream of the core and drives its single `ext_int` input.
- Latches up to NUM_SOURCES device interrupt lines into pending bits and applies a per-source enable mask.
- Provides a claim/complete register interface, so software services one interrupt at a time, lowest source index highest priority.
- The register interface uses the same req/busy stage handshake as the core's memory module.

---
 rtl/int_controller.sv | 163 ++++++++++++++++
 tb/tb_int_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
//
// Platform interrupt aggregator in front of the core's single ext_int input.
// Device lines are latched into pending bits and masked by a per-source
// enable. Software services one interrupt at a time through a claim/complete
// register. The lowest source index has the highest priority. Source i carries
// ID i+1, and ID 0 means "none".
//
// Register map (byte offsets):
//   0x0 PENDING         read-only, writes ignored
//   0x4 ENABLE          read/write, low NUM_SOURCES bits stored
//   0x8 CLAIM/COMPLETE  read = claim, write = complete
//   Any other offset, or a misaligned one, returns fault=1 and rdata=0.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-low reset
//   src      device interrupt lines, active-high, synchronous to clk
//   req      register access request, held until busy is low
//   write    1 = write, 0 = read
//   addr     byte offset
//   wdata    write data
//   rdata    read data, valid once busy falls with req high
//   busy     access in progress (combinational)
//   fault    illegal or misaligned access, valid with rdata
//   ext_int  registered interrupt request to the core
//
// Optional feature: define INTC_EDGE_TRIGGER_EN to pend on rising edges of
// src instead of on its level.
// -----------------------------------------------------------------------------
module int_controller #(
  parameter int NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] src,
  input  logic                   req,
  input  logic                   write,
  input  logic [3:0]             addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic                   fault,
  output logic                   ext_int
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                 state;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] enable;
  logic [NUM_SOURCES-1:0] qual;
  logic [NUM_SOURCES-1:0] set_mask;
  logic [NUM_SOURCES-1:0] claim_mask;
  logic [NUM_SOURCES-1:0] clr_mask;
  logic [4:0]             in_service_id;
  logic [4:0]             claim_id;
  logic                   addr_bad;
  logic                   do_claim;
  logic                   unused_wdata;

  assign unused_wdata = ^wdata[31:NUM_SOURCES];

  assign busy     = req & (state != DONE);
  assign qual     = pending & enable;
  assign addr_bad = (addr[1:0] != 2'b00) | (addr[3:2] == 2'b11);

  // Priority encoder: scanning from the top down leaves the lowest set
  // index as the final winner.
  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (qual[i]) begin
        claim_id      = 5'(i + 1);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  // A claim only takes effect when nothing is already in service.
  assign do_claim = (state == ACCESS) & ~addr_bad & ~write & (addr[3:2] == 2'b10) &
                    (in_service_id == 5'd0) & (claim_id != 5'd0);
  assign clr_mask = do_claim ? claim_mask : '0;

`ifdef INTC_EDGE_TRIGGER_EN
  logic [NUM_SOURCES-1:0] src_prev;

  // The previous-value flops reset low, so a line that is already high at
  // reset release still pends once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) src_prev <= '0;
    else        src_prev <= src;
  end

  assign set_mask = src & ~src_prev;
`else
  assign set_mask = src;
`endif

  // A new set takes priority over a claim-clear on the same bit in the same
  // cycle. ext_int is computed from the pre-edge state, so it follows the
  // qualifying condition by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      ext_int <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      ext_int <= (|qual) & (in_service_id == 5'd0);
    end
  end

  // Handshake FSM and register operations. The operation runs in ACCESS,
  // and its results are held through DONE until the next ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      enable        <= '0;
      in_service_id <= '0;
      rdata         <= '0;
      fault         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) state <= ACCESS;
        end
        ACCESS: begin
          state <= DONE;
          rdata <= '0;
          fault <= addr_bad;
          if (!addr_bad) begin
            case (addr[3:2])
              2'b00: begin
                if (!write) rdata <= {{(32-NUM_SOURCES){1'b0}}, pending};
              end
              2'b01: begin
                if (write) enable <= wdata[NUM_SOURCES-1:0];
                else       rdata  <= {{(32-NUM_SOURCES){1'b0}}, enable};
              end
              2'b10: begin
                if (write) begin
                  if (wdata[4:0] == in_service_id) in_service_id <= 5'd0;
                end else if (do_claim) begin
                  in_service_id <= claim_id;
                  rdata         <= {27'd0, claim_id};
                end
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          if (!req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// -----------------------------------------------------------------------------
// tb_int_controller
//
// Self-checking bench for int_controller. Directed sequences and randomized
// traffic are compared against a cycle-level reference model. The model keeps
// pending, enable and the in-service ID as plain integers and applies the
// register rules arithmetically.
// The edge-trigger sequence is compiled only with INTC_EDGE_TRIGGER_EN.
// -----------------------------------------------------------------------------
module tb_int_controller;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src;
  logic          req;
  logic          write;
  logic [3:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          busy;
  logic          fault;
  logic          ext_int;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_pending;
  int m_enable;
  int m_isr;
  int m_prev;
  bit m_ext;
  int exp_rdata;
  bit exp_fault;

  int rd;

  int_controller #(.NUM_SOURCES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .req     (req),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .fault   (fault),
    .ext_int (ext_int)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the expected value, counting each call.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Return the 1-based ID of the lowest set bit, or 0 if no bit is set.
  function automatic int lowest_id(input int bits);
    for (int i = 0; i < N; i++)
      if (bits[i]) return i + 1;
    return 0;
  endfunction

  // Advance one clock. The model's next state comes from the pre-edge
  // inputs and state. When op is set, this edge is the one that performs a
  // register access.
  task automatic tick(input bit op, input bit wr, input int a, input int wd);
    int mask;
    int set_bits;
    int clr;
    int nxt_en;
    int nxt_isr;
    int id;
    bit nxt_ext;
    mask    = (1 << N) - 1;
    clr     = 0;
    nxt_en  = m_enable;
    nxt_isr = m_isr;
`ifdef INTC_EDGE_TRIGGER_EN
    set_bits = int'(src) & ~m_prev & mask;
`else
    set_bits = int'(src);
`endif
    nxt_ext = ((m_pending & m_enable) != 0) && (m_isr == 0);
    if (op) begin
      exp_rdata = 0;
      if ((a % 4) != 0 || a >= 12) begin
        exp_fault = 1'b1;
      end else begin
        exp_fault = 1'b0;
        case (a)
          0: if (!wr) exp_rdata = m_pending;
          4: begin
            if (wr) nxt_en = wd & mask;
            else    exp_rdata = m_enable;
          end
          8: begin
            if (wr) begin
              if ((wd & 31) == m_isr) nxt_isr = 0;
            end else begin
              id = lowest_id(m_pending & m_enable);
              if (m_isr == 0 && id != 0) begin
                clr       = 1 << (id - 1);
                nxt_isr   = id;
                exp_rdata = id;
              end
            end
          end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    m_pending = (m_pending & ~clr) | set_bits;
    m_enable  = nxt_en;
    m_isr     = nxt_isr;
    m_ext     = nxt_ext;
    m_prev    = int'(src);
    @(negedge clk);
    checkOutput("ext_int", {31'd0, ext_int}, {31'd0, m_ext});
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 0, 0);
  endtask

  // One full req/busy transaction. Output rd is the rdata observed at the end.
  task automatic applyStimulus(input bit wr, input int a, input int wd, output int rd_o);
    req   = 1'b1;
    write = wr;
    addr  = a[3:0];
    wdata = wd;
    #1;
    checkOutput("busy_first", {31'd0, busy}, 32'd1);
    tick(1'b0, 1'b0, 0, 0);
    checkOutput("busy_access", {31'd0, busy}, 32'd1);
    tick(1'b1, wr, a, wd);
    checkOutput("busy_done", {31'd0, busy}, 32'd0);
    checkOutput("rdata", rdata, exp_rdata);
    checkOutput("fault", {31'd0, fault}, {31'd0, exp_fault});
    rd_o = rdata;
    req  = 1'b0;
    tick(1'b0, 1'b0, 0, 0);
  endtask

  task automatic model_clear();
    m_pending = 0;
    m_enable  = 0;
    m_isr     = 0;
    m_prev    = 0;
    m_ext     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 1'b0;
    src   = '0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
    model_clear();
    #1;
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
    checkOutput("rst_ext", {31'd0, ext_int}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = 1'b0;
    src   = '0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
    @(negedge clk);
    do_reset();

    // Reads after reset return zero.
    applyStimulus(1'b0, 0, 0, rd);  checkOutput("rst_pending", rd, 0);
    applyStimulus(1'b0, 4, 0, rd);  checkOutput("rst_enable", rd, 0);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("rst_claim", rd, 0);

    // A one-cycle pulse on source 3 is claimed and the pending bit cleared.
    applyStimulus(1'b1, 4, 32'h05, rd);
    src = 8'h04;
    tick(1'b0, 1'b0, 0, 0);
    src = 8'h00;
    idle(2);
    checkOutput("pulse_ext", {31'd0, ext_int}, 32'd1);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("pulse_claim", rd, 3);
    applyStimulus(1'b0, 0, 0, rd);  checkOutput("pulse_pending", rd, 0);
    applyStimulus(1'b1, 8, 3, rd);

    // Level mode with two sources held high.
    do_reset();
    src = 8'h06;
    applyStimulus(1'b1, 4, 32'h06, rd);
    idle(1);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("lvl_claim1", rd, 2);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("lvl_claim2", rd, 0);
    applyStimulus(1'b1, 8, 5, rd);
    applyStimulus(1'b1, 8, 2, rd);
    idle(1);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("lvl_claim3", rd, 2);
    applyStimulus(1'b1, 8, 2, rd);
    // Completing while nothing is in service changes nothing.
    applyStimulus(1'b1, 8, 2, rd);

    // A masked source still pends; enabling it raises ext_int.
    do_reset();
    src = 8'h80;
    idle(2);
    applyStimulus(1'b0, 0, 0, rd);  checkOutput("mask_pending", rd, 32'h80);
    applyStimulus(1'b1, 4, 32'h80, rd);
    idle(1);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("mask_claim", rd, 8);
    src = 8'h00;

    // Illegal and misaligned accesses fault without changing state.
    applyStimulus(1'b0, 2, 0, rd);
    applyStimulus(1'b0, 12, 0, rd);
    applyStimulus(1'b1, 12, 32'hFF, rd);
    applyStimulus(1'b1, 5, 32'hFF, rd);
    applyStimulus(1'b0, 4, 0, rd);  checkOutput("bad_enable", rd, 32'h80);
    applyStimulus(1'b0, 0, 0, rd);

`ifdef INTC_EDGE_TRIGGER_EN
    // A held-high line pends only once.
    do_reset();
    src = 8'h01;
    idle(10);
    src = 8'h00;
    applyStimulus(1'b1, 4, 32'h01, rd);
    idle(1);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("edge_claim1", rd, 1);
    applyStimulus(1'b1, 8, 1, rd);
    applyStimulus(1'b0, 8, 0, rd);  checkOutput("edge_claim2", rd, 0);
`endif

    // Reset during an access discards the partial ENABLE write.
    do_reset();
    req   = 1'b1;
    write = 1'b1;
    addr  = 4'h4;
    wdata = 32'hFF;
    tick(1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    model_clear();
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd1);
    req = 1'b0;
    #1;
    checkOutput("midrst_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 4, 0, rd);  checkOutput("midrst_enable", rd, 0);

    // Randomized traffic checked against the model.
    do_reset();
    for (int it = 0; it < 300; it++) begin
      int choice;
      int a;
      int wd;
      bit wr;
      int addr_tab[8];
      addr_tab = '{0, 4, 8, 8, 8, 2, 12, 0};
      choice = $urandom_range(0, 9);
      if (choice <= 2) begin
        src = N'($urandom);
        tick(1'b0, 1'b0, 0, 0);
      end else if (choice == 3) begin
        idle($urandom_range(1, 3));
      end else begin
        a = addr_tab[$urandom_range(0, 7)];
        if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 15);
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (a == 8 && wr && $urandom_range(0, 2) != 0) wd = m_isr;
        applyStimulus(wr, a, wd, rd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
